// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between NREQ writeback sources
//   using round-robin valid/ready arbitration. The winning write is registered
//   and presented one cycle later. A pending-write scoreboard keeps one busy
//   bit per register, so the issue stage can stall on RAW hazards.
//
// Ports
//   clk        clock
//   rst        asynchronous, active-high reset
//   req_valid  [NREQ]       requester i has a write pending
//   req_ready  [NREQ]       requester i granted this cycle (one-hot or zero)
//   req_rd     [NREQ*AW]    dest reg of requester i, slice [i*AW +: AW]
//   req_data   [NREQ*XLEN]  write data of requester i, slice [i*XLEN +: XLEN]
//   rf_wen     register-file write enable
//   rf_rd      [AW]         register-file write address
//   rf_wdata   [XLEN]       register-file write data
//   iss_set    issue stage dispatched an instruction writing iss_rd
//   iss_rd     [AW]         dest reg of the dispatched instruction
//   chk_rs1/2  [AW]         source regs to check
//   busy_rs1/2 source reg has a write in flight (state at start of cycle)
module wb_port_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic                 rf_wen,
  output logic [AW-1:0]        rf_rd,
  output logic [XLEN-1:0]      rf_wdata,
  input  logic                 iss_set,
  input  logic [AW-1:0]        iss_rd,
  input  logic [AW-1:0]        chk_rs1,
  input  logic [AW-1:0]        chk_rs2,
  output logic                 busy_rs1,
  output logic                 busy_rs2
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_nxt;
  logic [PW-1:0]   grant_idx;
  logic            grant_any;
  logic [AW-1:0]   rd_sel;
  logic [XLEN-1:0] data_sel;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  // Search starts at ptr and wraps, so the most recent winner goes last.
  always_comb begin
    int j;
    req_ready = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    j = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!grant_any && req_valid[j]) begin
        grant_any = 1'b1;
        grant_idx = PW'(j);
      end
    end
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  assign rd_sel   = req_rd[int'(grant_idx)*AW +: AW];
  assign data_sel = req_data[int'(grant_idx)*XLEN +: XLEN];

  always_comb begin
    ptr_nxt = ptr;
    if (grant_any) begin
      if (grant_idx == PW'(NREQ-1)) ptr_nxt = '0;
      else                          ptr_nxt = grant_idx + PW'(1);
    end
  end

  // A write to x0 is consumed but never reaches the register file;
  // address/data still update so the port shows what was accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      rf_wen   <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      ptr <= ptr_nxt;
      if (grant_any) begin
        rf_wen   <= (rd_sel != '0);
        rf_rd    <= rd_sel;
        rf_wdata <= data_sel;
      end else begin
        rf_wen <= 1'b0;
      end
    end
  end

  // Clear is applied before set so a same-edge set for the same register
  // wins: that register now belongs to a newer in-flight instruction.
  always_comb begin
    busy_nxt = busy;
    if (rf_wen) busy_nxt[rf_rd] = 1'b0;
    if (iss_set && (iss_rd != '0)) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign busy_rs1 = busy[chk_rs1];
  assign busy_rs2 = busy[chk_rs2];

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_rd = '0;
  logic [NREQ*XLEN-1:0] req_data = '0;
  logic                 rf_wen;
  logic [AW-1:0]        rf_rd;
  logic [XLEN-1:0]      rf_wdata;
  logic                 iss_set = 1'b0;
  logic [AW-1:0]        iss_rd = '0;
  logic [AW-1:0]        chk_rs1 = '0;
  logic [AW-1:0]        chk_rs2 = '0;
  logic                 busy_rs1;
  logic                 busy_rs2;

  int checks = 0;
  int failures = 0;

  wb_port_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .iss_set(iss_set), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
    iss_set   = 1'b0;
    iss_rd    = '0;
    chk_rs1   = '0;
    chk_rs2   = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (rf_wen !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: wen=%b rd=%0d wdata=%h required 0/0/0", rf_wen, rf_rd, rf_wdata);
    end
    checks++;
    if (req_ready !== 3'b000 || busy_rs1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: ready=%b busy=%b required 000/0", req_ready, busy_rs1);
    end
    rst = 1'b0;
    iss_set = 1'b1; iss_rd = 5'd7;
    req_valid = 3'b001; req_rd[0 +: AW] = 5'd3; req_data[0 +: XLEN] = 32'h0000_00AA;
    tick();
    clear_inputs();
    chk_rs1 = 5'd7;
    #1;
    checks++;
    if (busy_rs1 !== 1'b1 || rf_wen !== 1'b1) begin
      failures++;
      $display("FAIL reset_setup: busy7=%b wen=%b required 1/1", busy_rs1, rf_wen);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (rf_wen !== 1'b0 || busy_rs1 !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_async: wen=%b busy7=%b rd=%0d wdata=%h required 0/0/0/0", rf_wen, busy_rs1, rf_rd, rf_wdata);
    end
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single_write();
    req_valid = 3'b001; req_rd[0 +: AW] = 5'd5; req_data[0 +: XLEN] = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      failures++;
      $display("FAIL single_ready: got %b required 001", req_ready);
    end
    tick();
    clear_inputs();
    checks++;
    if (rf_wen !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL single_write: wen=%b rd=%0d wdata=%h required 1/5/deadbeef", rf_wen, rf_rd, rf_wdata);
    end
    tick();
    checks++;
    if (rf_wen !== 1'b0 || rf_rd !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL single_idle: wen=%b rd=%0d wdata=%h required 0/5/deadbeef (hold)", rf_wen, rf_rd, rf_wdata);
    end
  endtask

  task automatic test_round_robin();
    int exp_grant [9] = '{0, 1, 2, 0, 1, 2, 0, 2, 0};
    logic [NREQ-1:0] exp_ready;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_rd[i*AW +: AW]       = AW'(i + 1);
      req_data[i*XLEN +: XLEN] = 32'h100 + i;
    end
    req_valid = 3'b111;
    for (int n = 0; n < 9; n++) begin
      #1;
      exp_ready = '0;
      exp_ready[exp_grant[n]] = 1'b1;
      checks++;
      if (req_ready !== exp_ready) begin
        failures++;
        $display("FAIL rr_grant[%0d]: got %b required %b", n, req_ready, exp_ready);
      end
      tick();
      if (n == 4) req_valid[1] = 1'b0;
      checks++;
      if (rf_wen !== 1'b1 || rf_rd !== AW'(exp_grant[n] + 1) || rf_wdata !== 32'h100 + exp_grant[n]) begin
        failures++;
        $display("FAIL rr_write[%0d]: wen=%b rd=%0d wdata=%h required 1/%0d/%h",
                 n, rf_wen, rf_rd, rf_wdata, exp_grant[n] + 1, 32'h100 + exp_grant[n]);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_x0();
    req_valid = 3'b100; req_rd[2*AW +: AW] = 5'd0; req_data[2*XLEN +: XLEN] = 32'h0000_1234;
    iss_set = 1'b1; iss_rd = 5'd0;
    chk_rs1 = 5'd0;
    #1;
    checks++;
    if (req_ready !== 3'b100) begin
      failures++;
      $display("FAIL x0_ready: got %b required 100", req_ready);
    end
    tick();
    req_valid = '0; iss_set = 1'b0;
    #1;
    checks++;
    if (rf_wen !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 32'h0000_1234) begin
      failures++;
      $display("FAIL x0_write: wen=%b rd=%0d wdata=%h required 0/0/00001234", rf_wen, rf_rd, rf_wdata);
    end
    checks++;
    if (busy_rs1 !== 1'b0) begin
      failures++;
      $display("FAIL x0_busy: got %b required 0", busy_rs1);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    clear_inputs();
    chk_rs1 = 5'd9; chk_rs2 = 5'd10;
    iss_set = 1'b1; iss_rd = 5'd9;
    #1;
    checks++;
    if (busy_rs1 !== 1'b0) begin
      failures++;
      $display("FAIL sb_no_bypass: got %b required 0", busy_rs1);
    end
    tick();
    iss_set = 1'b0;
    #1;
    checks++;
    if (busy_rs1 !== 1'b1 || busy_rs2 !== 1'b0) begin
      failures++;
      $display("FAIL sb_set: busy9=%b busy10=%b required 1/0", busy_rs1, busy_rs2);
    end
    req_valid = 3'b010; req_rd[1*AW +: AW] = 5'd9; req_data[1*XLEN +: XLEN] = 32'h0000_0909;
    tick();
    req_valid = '0;
    #1;
    checks++;
    if (rf_wen !== 1'b1 || rf_rd !== 5'd9 || busy_rs1 !== 1'b1) begin
      failures++;
      $display("FAIL sb_commit_cycle: wen=%b rd=%0d busy9=%b required 1/9/1", rf_wen, rf_rd, busy_rs1);
    end
    tick();
    checks++;
    if (busy_rs1 !== 1'b0) begin
      failures++;
      $display("FAIL sb_clear: got %b required 0", busy_rs1);
    end
    iss_set = 1'b1; iss_rd = 5'd9;
    tick();
    iss_set = 1'b0;
    req_valid = 3'b010;
    tick();
    req_valid = '0;
    iss_set = 1'b1; iss_rd = 5'd9;
    #1;
    checks++;
    if (rf_wen !== 1'b1 || rf_rd !== 5'd9 || busy_rs1 !== 1'b1) begin
      failures++;
      $display("FAIL sb_commit2: wen=%b rd=%0d busy9=%b required 1/9/1", rf_wen, rf_rd, busy_rs1);
    end
    tick();
    iss_set = 1'b0;
    #1;
    checks++;
    if (busy_rs1 !== 1'b1) begin
      failures++;
      $display("FAIL sb_set_wins: got %b required 1", busy_rs1);
    end
    tick();
    checks++;
    if (busy_rs1 !== 1'b1) begin
      failures++;
      $display("FAIL sb_hold: got %b required 1", busy_rs1);
    end
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] exp_ready [3] = '{3'b010, 3'b100, 3'b001};
    do_reset();
    req_valid = 3'b001; req_rd[0 +: AW] = 5'd1;
    tick();
    req_rd[0 +: AW]  = 5'd17; req_data[0 +: XLEN]  = 32'hCAFE_0000;
    req_rd[AW +: AW] = 5'd18; req_data[XLEN +: XLEN] = 32'hCAFE_0001;
    req_rd[2*AW +: AW] = 5'd19; req_data[2*XLEN +: XLEN] = 32'hCAFE_0002;
    req_valid = 3'b111;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++;
      if (req_ready !== exp_ready[n]) begin
        failures++;
        $display("FAIL bp_grant[%0d]: got %b required %b", n, req_ready, exp_ready[n]);
      end
      tick();
      if (n == 0) req_valid[1] = 1'b0;
      if (n == 1) req_valid[2] = 1'b0;
    end
    req_valid = '0;
    checks++;
    if (rf_wen !== 1'b1 || rf_rd !== 5'd17 || rf_wdata !== 32'hCAFE_0000) begin
      failures++;
      $display("FAIL bp_capture: wen=%b rd=%0d wdata=%h required 1/17/cafe0000", rf_wen, rf_rd, rf_wdata);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_x0();
    test_scoreboard();
    test_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
